// File: rtl/osd_trace_depacketization.sv
// Rebuilds DII trace-event / overflow-status packets into one parallel trace word.
// Malformed packets raise a one-cycle err and are discarded through their last flit.
module osd_trace_depacketization #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             debug_in_valid,
  input  logic             debug_in_last,
  input  logic [15:0]      debug_in_data,
  output logic             debug_in_ready,
  output logic [WIDTH-1:0] trace_data,
  output logic             trace_overflow,
  output logic [9:0]       trace_id,
  output logic             trace_valid,
  input  logic             trace_ready,
  output logic             err
);

  localparam int NUM_FLITS = (WIDTH + 15) / 16;
  localparam int LAST_BITS = WIDTH - (NUM_FLITS - 1) * 16;
  localparam int CNT_W     = (NUM_FLITS > 1) ? $clog2(NUM_FLITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_FLITS - 1);

  typedef enum logic [2:0] {
    DEST,
    HEADER,
    EVENT,
    STATUS,
    OUTPUT,
    DROP
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   counter_q, counter_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic [9:0]         id_q, id_d;
  logic               ovf_q, ovf_d;
  logic               err_q, err_d;
  logic               accept;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= DEST;
      counter_q <= '0;
      data_q    <= '0;
      id_q      <= '0;
      ovf_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      counter_q <= counter_d;
      data_q    <= data_d;
      id_q      <= id_d;
      ovf_q     <= ovf_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    counter_d      = counter_q;
    data_d         = data_q;
    id_d           = id_q;
    ovf_d          = ovf_q;
    err_d          = 1'b0;
    debug_in_ready = (state_q != OUTPUT);
    accept         = debug_in_valid && debug_in_ready;

    case (state_q)
      DEST: begin
        if (accept) begin
          if (debug_in_last) err_d = 1'b1;
          else               state_d = HEADER;
        end
      end

      HEADER: begin
        if (accept) begin
          if (debug_in_last) begin
            err_d   = 1'b1;
            state_d = DEST;
          end else if (debug_in_data[15:14] != 2'b10 || debug_in_data[10]) begin
            err_d   = 1'b1;
            state_d = DROP;
          end else begin
            id_d      = debug_in_data[9:0];
            ovf_d     = debug_in_data[11];
            counter_d = '0;
            // Assembly overwrites the output register, so wipe it first.
            data_d    = '0;
            state_d   = debug_in_data[11] ? STATUS : EVENT;
          end
        end
      end

      EVENT: begin
        if (accept) begin
          if (counter_q != CNT_LAST) begin
            if (debug_in_last) begin
              err_d   = 1'b1;
              state_d = DEST;
            end else begin
              for (int i = 0; i < NUM_FLITS - 1; i++) begin
                if (counter_q == CNT_W'(i)) data_d[i*16 +: 16] = debug_in_data;
              end
              counter_d = counter_q + CNT_W'(1);
            end
          end else if (debug_in_last) begin
            // Fill bits above LAST_BITS are padding and deliberately dropped.
            data_d[(NUM_FLITS-1)*16 +: LAST_BITS] = debug_in_data[LAST_BITS-1:0];
            state_d = OUTPUT;
          end else begin
            err_d   = 1'b1;
            state_d = DROP;
          end
        end
      end

      STATUS: begin
        if (accept) begin
          if (debug_in_last && debug_in_data[15]) begin
            data_d  = WIDTH'(debug_in_data[9:0]);
            state_d = OUTPUT;
          end else if (debug_in_last) begin
            err_d   = 1'b1;
            state_d = DEST;
          end else begin
            err_d   = 1'b1;
            state_d = DROP;
          end
        end
      end

      OUTPUT: begin
        if (trace_ready) state_d = DEST;
      end

      DROP: begin
        if (accept && debug_in_last) state_d = DEST;
      end

      default: state_d = DEST;
    endcase
  end

  assign trace_data     = data_q;
  assign trace_overflow = ovf_q;
  assign trace_id       = id_q;
  assign trace_valid    = (state_q == OUTPUT);
  assign err            = err_q;

endmodule

// File: tb/tb_osd_trace_depacketization.sv
// Directed bench for osd_trace_depacketization: a WIDTH=32 instance and a WIDTH=20 instance.
module tb_osd_trace_depacketization;

  logic        clk;
  logic        rst;

  logic        v32, l32, r32, tr32, tv32, ov32, e32;
  logic [15:0] d32;
  logic [31:0] td32;
  logic [9:0]  id32;

  logic        v20, l20, r20, tr20, tv20, ov20, e20;
  logic [15:0] d20;
  logic [19:0] td20;
  logic [9:0]  id20;

  int checks = 0;
  int errors = 0;

  osd_trace_depacketization #(.WIDTH(32)) u32 (
    .clk(clk), .rst(rst),
    .debug_in_valid(v32), .debug_in_last(l32), .debug_in_data(d32), .debug_in_ready(r32),
    .trace_data(td32), .trace_overflow(ov32), .trace_id(id32),
    .trace_valid(tv32), .trace_ready(tr32), .err(e32)
  );

  osd_trace_depacketization #(.WIDTH(20)) u20 (
    .clk(clk), .rst(rst),
    .debug_in_valid(v20), .debug_in_last(l20), .debug_in_data(d20), .debug_in_ready(r20),
    .trace_data(td20), .trace_overflow(ov20), .trace_id(id20),
    .trace_valid(tv20), .trace_ready(tr20), .err(e20)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Offer one flit to the selected instance and return once it has been taken.
  task automatic send_flit(input int sel, input logic [15:0] dat, input logic last);
    bit done = 0;
    if (sel == 0) begin v32 = 1'b1; d32 = dat; l32 = last; end
    else          begin v20 = 1'b1; d20 = dat; l20 = last; end
    for (int n = 0; n < 50 && !done; n++) begin
      @(negedge clk);
      if ((sel == 0) ? r32 : r20) done = 1;
      @(posedge clk);
      #1;
    end
    if (sel == 0) begin v32 = 1'b0; l32 = 1'b0; end
    else          begin v20 = 1'b0; l20 = 1'b0; end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL flit_accept_timeout: sel=%0d data=%h not accepted within 50 cycles", sel, dat);
    end
  endtask

  task automatic pop32();
    tr32 = 1'b1;
    @(posedge clk);
    #1;
    tr32 = 1'b0;
    checks++;
    if (tv32 !== 1'b0) begin
      errors++;
      $display("FAIL pop32_valid_low: trace_valid=%b expected 0", tv32);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    checks++; if (tv32 !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", tv32); end
    checks++; if (td32 !== 32'h0) begin errors++; $display("FAIL reset_data: got %h expected 0", td32); end
    checks++; if (id32 !== 10'h0) begin errors++; $display("FAIL reset_id: got %h expected 0", id32); end
    checks++; if (ov32 !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b expected 0", ov32); end
    checks++; if (e32 !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", e32); end
    checks++; if (r32 !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", r32); end
    checks++; if (tv20 !== 1'b0) begin errors++; $display("FAIL reset_valid20: got %b expected 0", tv20); end
  endtask

  task automatic test_event32();
    send_flit(0, 16'h0000, 1'b0);
    send_flit(0, 16'h8005, 1'b0);
    send_flit(0, 16'h5678, 1'b0);
    checks++; if (tv32 !== 1'b0) begin errors++; $display("FAIL event_early_valid: got %b expected 0", tv32); end
    send_flit(0, 16'hD234, 1'b1);
    checks++; if (tv32 !== 1'b1) begin errors++; $display("FAIL event_valid: got %b expected 1", tv32); end
    checks++; if (td32 !== 32'hD2345678) begin errors++; $display("FAIL event_data: got %h expected d2345678", td32); end
    checks++; if (id32 !== 10'd5) begin errors++; $display("FAIL event_id: got %h expected 005", id32); end
    checks++; if (ov32 !== 1'b0) begin errors++; $display("FAIL event_ovf: got %b expected 0", ov32); end
    checks++; if (e32 !== 1'b0) begin errors++; $display("FAIL event_err: got %b expected 0", e32); end
    checks++; if (r32 !== 1'b0) begin errors++; $display("FAIL event_ready_in_output: got %b expected 0", r32); end
    pop32();
  endtask

  task automatic test_status32();
    send_flit(0, 16'h0000, 1'b0);
    send_flit(0, 16'h8805, 1'b0);
    send_flit(0, 16'h8003, 1'b1);
    checks++; if (tv32 !== 1'b1) begin errors++; $display("FAIL status_valid: got %b expected 1", tv32); end
    checks++; if (ov32 !== 1'b1) begin errors++; $display("FAIL status_ovf: got %b expected 1", ov32); end
    checks++; if (id32 !== 10'd5) begin errors++; $display("FAIL status_id: got %h expected 005", id32); end
    checks++; if (td32 !== 32'h00000003) begin errors++; $display("FAIL status_data: got %h expected 00000003", td32); end
    pop32();
  endtask

  task automatic test_width20();
    send_flit(1, 16'h0000, 1'b0);
    send_flit(1, 16'h83FF, 1'b0);
    send_flit(1, 16'hABCD, 1'b0);
    send_flit(1, 16'hFFF7, 1'b1);
    checks++; if (tv20 !== 1'b1) begin errors++; $display("FAIL w20_valid: got %b expected 1", tv20); end
    checks++; if (td20 !== 20'h7ABCD) begin errors++; $display("FAIL w20_data: got %h expected 7abcd", td20); end
    checks++; if (id20 !== 10'h3FF) begin errors++; $display("FAIL w20_id: got %h expected 3ff", id20); end
    checks++; if (e20 !== 1'b0) begin errors++; $display("FAIL w20_err: got %b expected 0", e20); end
    tr20 = 1'b1;
    @(posedge clk);
    #1;
    tr20 = 1'b0;
    checks++; if (tv20 !== 1'b0) begin errors++; $display("FAIL w20_pop: got %b expected 0", tv20); end
  endtask

  task automatic test_backpressure();
    send_flit(0, 16'h0000, 1'b0);
    send_flit(0, 16'h8007, 1'b0);
    send_flit(0, 16'h1111, 1'b0);
    send_flit(0, 16'h2222, 1'b1);
    // Next packet's DEST flit is waiting while the sink stalls.
    v32 = 1'b1; d32 = 16'h0000; l32 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++; if (r32 !== 1'b0) begin errors++; $display("FAIL bp_ready cycle %0d: got %b expected 0", i, r32); end
      checks++; if (tv32 !== 1'b1 || td32 !== 32'h22221111 || id32 !== 10'd7 || ov32 !== 1'b0) begin
        errors++;
        $display("FAIL bp_stable cycle %0d: valid=%b data=%h id=%h ovf=%b expected 1/22221111/007/0", i, tv32, td32, id32, ov32);
      end
    end
    tr32 = 1'b1;
    @(posedge clk);
    #1;
    tr32 = 1'b0;
    checks++; if (tv32 !== 1'b0) begin errors++; $display("FAIL bp_release_valid: got %b expected 0", tv32); end
    checks++; if (r32 !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %b expected 1", r32); end
    send_flit(0, 16'h0000, 1'b0);
    send_flit(0, 16'h8009, 1'b0);
    send_flit(0, 16'hBEEF, 1'b0);
    send_flit(0, 16'h0123, 1'b1);
    checks++; if (tv32 !== 1'b1 || td32 !== 32'h0123BEEF || id32 !== 10'd9) begin
      errors++;
      $display("FAIL bp_next_packet: valid=%b data=%h id=%h expected 1/0123beef/009", tv32, td32, id32);
    end
    pop32();
  endtask

  task automatic test_malformed();
    send_flit(0, 16'h0000, 1'b0);
    send_flit(0, 16'h4005, 1'b0);
    checks++; if (e32 !== 1'b1) begin errors++; $display("FAIL bad_type_err: got %b expected 1", e32); end
    send_flit(0, 16'h1234, 1'b0);
    checks++; if (e32 !== 1'b0) begin errors++; $display("FAIL drop_no_repeat_err: got %b expected 0", e32); end
    send_flit(0, 16'h5678, 1'b1);
    checks++; if (e32 !== 1'b0 || tv32 !== 1'b0) begin
      errors++; $display("FAIL drop_end: err=%b valid=%b expected 0/0", e32, tv32);
    end
    send_flit(0, 16'h0000, 1'b0);
    send_flit(0, 16'h8005, 1'b0);
    send_flit(0, 16'h1111, 1'b1);
    checks++; if (e32 !== 1'b1) begin errors++; $display("FAIL short_err: got %b expected 1", e32); end
    checks++; if (tv32 !== 1'b0) begin errors++; $display("FAIL short_no_valid: got %b expected 0", tv32); end
    send_flit(0, 16'h0000, 1'b0);
    send_flit(0, 16'h8002, 1'b0);
    send_flit(0, 16'hAAAA, 1'b0);
    send_flit(0, 16'h5555, 1'b1);
    checks++; if (tv32 !== 1'b1 || td32 !== 32'h5555AAAA || id32 !== 10'd2 || e32 !== 1'b0) begin
      errors++;
      $display("FAIL good_after_bad: valid=%b data=%h id=%h err=%b expected 1/5555aaaa/002/0", tv32, td32, id32, e32);
    end
    pop32();
  endtask

  task automatic test_reset_mid();
    send_flit(0, 16'h0000, 1'b0);
    send_flit(0, 16'h8815, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checks++; if (id32 !== 10'h0) begin errors++; $display("FAIL midrst_id: got %h expected 000", id32); end
    checks++; if (ov32 !== 1'b0) begin errors++; $display("FAIL midrst_ovf: got %b expected 0", ov32); end
    checks++; if (tv32 !== 1'b0 || td32 !== 32'h0 || e32 !== 1'b0 || r32 !== 1'b1) begin
      errors++;
      $display("FAIL midrst_outputs: valid=%b data=%h err=%b ready=%b expected 0/0/0/1", tv32, td32, e32, r32);
    end
    send_flit(0, 16'h0000, 1'b0);
    send_flit(0, 16'h8006, 1'b0);
    send_flit(0, 16'h4444, 1'b0);
    send_flit(0, 16'h3333, 1'b1);
    checks++; if (tv32 !== 1'b1 || td32 !== 32'h33334444 || id32 !== 10'd6 || ov32 !== 1'b0) begin
      errors++;
      $display("FAIL midrst_next: valid=%b data=%h id=%h ovf=%b expected 1/33334444/006/0", tv32, td32, id32, ov32);
    end
    pop32();
  endtask

  initial begin
    rst = 1'b1;
    v32 = 1'b0; l32 = 1'b0; d32 = '0; tr32 = 1'b0;
    v20 = 1'b0; l20 = 1'b0; d20 = '0; tr20 = 1'b0;
    test_reset();
    test_event32();
    test_status32();
    test_width20();
    test_backpressure();
    test_malformed();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
